// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned LAT_DEFAULT = 1;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   we;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,  // 1: requester 1 won the previous accept
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one fixed-latency memory port, one
// transaction outstanding; writes finish in the accept cycle, reads respond LAT+1 later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [BE_W-1:0]   req0_we,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [BE_W-1:0]   req1_we,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LAT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        grant;
  mem_req_t          win;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign win = grant[1] ? {req1_addr, req1_wdata, req1_we}
                        : {req0_addr, req0_wdata, req0_we};

  // Next-state, accept strobes and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    owner_d    = owner_q;
    rvalid_d   = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = '0;
    case (state_q)
      IDLE: begin
        if (!reset && (grant != 2'b00)) begin
          req0_ready = grant[0];
          req1_ready = grant[1];
          mem_en     = 1'b1;
          mem_addr   = win.addr;
          mem_wdata  = win.wdata;
          mem_we     = win.we;
          last_d     = grant[1];
          if (win.we == '0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LAT);
            owner_d = grant[1];
          end
        end
      end
      WAIT: begin
        // Counter reaches 1 in the cycle mem_rdata is valid; it never goes below 0.
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d    = '0;
          state_d  = RESP;
          rvalid_d = owner_q ? 2'b10 : 2'b01;
          if (owner_q) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Responses are masked while reset is held so an aborted read never surfaces.
  assign req0_rvalid = rvalid_q[0] & ~reset;
  assign req1_rvalid = rvalid_q[1] & ~reset;
  assign req0_rdata  = reset ? '0 : rdata0_q;
  assign req1_rdata  = reset ? '0 : rdata1_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 1, sets the memory read latency in cycles; legal range 1..4.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents a transaction.
REQ-005 reqN_ready  output  1  transaction of requester N accepted this cycle.
REQ-006 reqN_addr  input  32  byte address.
REQ-007 reqN_wdata  input  32  write data.
REQ-008 reqN_we  input  4  byte write enables; 0 means read.
REQ-009 reqN_rvalid  output  1  one-cycle read response pulse.
REQ-010 reqN_rdata  output  32  read data, valid while reqN_rvalid=1.
REQ-011 mem_en  output  1  memory access strobe.
REQ-012 mem_addr, mem_wdata  output  32 each  driven from the accepted request.
REQ-013 mem_we  output  4  driven from the accepted request.
REQ-014 mem_rdata  input  32  valid exactly LAT cycles after the mem_en cycle.

Function
REQ-015 States SHALL be IDLE, WAIT and RESP; at most one transaction is outstanding.
REQ-016 In IDLE the block SHALL assert reqN_ready combinationally for the single arbitration winner among asserted valids; ready SHALL be 0 in WAIT and RESP.
REQ-017 The accept cycle (valid & ready) SHALL drive mem_en=1 with the winner's addr/wdata/we in that same cycle; otherwise mem_en=0 and mem_we=0.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it regardless of pointer.
REQ-019 The last-grant pointer SHALL update only on accept.
REQ-020 Write accept (we!=0): complete in the accept cycle with no rvalid; stay in IDLE, so the next accept is possible the following cycle.
REQ-021 Read accept (we==0): go to WAIT and load a down-counter with LAT.
REQ-022 In WAIT, when the counter expires (LAT cycles after accept), the block SHALL register mem_rdata and go to RESP.
REQ-023 In RESP, the block SHALL assert rvalid for the owning requester only, for exactly one cycle, with the registered data, then return to IDLE.
REQ-024 Read accept-to-rvalid latency SHALL be LAT+1 cycles; read occupancy SHALL be LAT+2 cycles.
REQ-025 reqN_rdata SHALL hold its last value between responses.
REQ-026 Requesters SHALL hold valid and payload stable until ready; the arbiter SHALL not depend on a deasserted valid being re-presented.
REQ-027 The counter width SHALL be clog2(LAT+1) bits; the counter SHALL not wrap.

Reset
REQ-028 Reset SHALL force IDLE, counter 0, and the pointer to favour req0.
REQ-029 During reset all ready, rvalid, mem_en and mem_we outputs SHALL be 0, and rdata outputs SHALL be 0.
REQ-030 Reset in WAIT or RESP SHALL abort the read; no rvalid SHALL be issued for it.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the state encoding, the LAT default, and the address and data widths.
REQ-032 Round-robin grant logic SHALL be the sub-module rr_arb2 (inputs: two valids, pointer; output: one-hot grant).

Verification
REQ-033 After reset, req0 writes 0xDEADBEEF to 0x10 with we=0xF -> mem_en=1, mem_we=0xF and req0_ready=1 in the same cycle; no rvalid.
REQ-034 With LAT=2, req1 reads 0x10 and memory returns 0xDEADBEEF -> req1_rvalid=1 with rdata 0xDEADBEEF exactly 3 cycles after accept; req0_rvalid stays 0.
REQ-035 Both valid for four consecutive writes -> grant order req0, req1, req0, req1.
REQ-036 req0 holds a read while req1 issues a read back-to-back -> the second accept occurs no earlier than LAT+2 cycles after the first.
REQ-037 Reset asserted in WAIT -> no rvalid, IDLE next cycle, and the first post-reset tie grants req0.
